// File: rtl/minority_bist_pkg.sv
// Shared definitions for the minority-gate self-test block.
//   - state_t and the St* state constants of the sweep FSM
//   - NUM_VECTORS: number of input vectors in one sweep (all 3-bit patterns)
//   - minority_exp(): golden value of a 3-input minority gate
package minority_bist_pkg;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned IdxW        = 3;
  localparam int unsigned ErrW        = 4;

  // Plain constants keep the encoding visible for legacy tools and waveform decoders.
  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StApply = 3'd1;
  localparam state_t StWait  = 3'd2;
  localparam state_t StCheck = 3'd3;
  localparam state_t StDone  = 3'd4;

  // A minority gate is the inverse of a majority gate: high when fewer than two inputs are high.
  function automatic logic minority_exp(input logic [IdxW-1:0] v);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    return ~maj;
  endfunction

endpackage

// File: rtl/minority_bist_timer.sv
// Settle-time down-counter for the WAIT phase of the sweep.
//   clk_i     : clock
//   reset_i   : synchronous active-high reset
//   load_i    : reload the counter with SETTLE (held while not settling)
//   en_i      : count down by one per cycle, saturating at zero
//   expired_o : counter has reached zero
module minority_bist_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 4'(SETTLE);
    end else if (en_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= 4'(SETTLE);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 4'd0);

endmodule

// File: rtl/minority_bist.sv
// Built-in self test for an external 3-input minority gate.
// On start, drives all eight input vectors in order, waits SETTLE cycles per vector, compares the
// gate output against the golden minority value and records mismatches.
//   clk, reset      : clock, synchronous active-high reset
//   start, abort    : begin a sweep (IDLE/DONE only) / cancel back to IDLE
//   y_dut           : output of the gate under test
//   a, b, c         : stimulus to the gate under test ({a,b,c} == vector index)
//   busy, done      : sweep in progress / sweep finished
//   pass            : finished sweep with no mismatches
//   err_count       : number of mismatching vectors
//   fail_vec        : bit i set when vector i mismatched
module minority_bist
  import minority_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       y_dut,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  state_t                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [ErrW-1:0]          err_q, err_d;
  logic [NUM_VECTORS-1:0]   fail_q, fail_d;
  logic                     settling;
  logic                     expired;

  // Counter runs through APPLY so that exactly SETTLE cycles are spent in WAIT.
  assign settling = (state_q == StApply) || (state_q == StWait);

  minority_bist_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (~settling),
    .en_i      (settling),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StApply;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      StApply: begin
        if (SETTLE == 0) begin
          state_d = StCheck;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (expired) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (y_dut != minority_exp(idx_q)) begin
          if (err_q < ErrW'(NUM_VECTORS)) begin
            err_d = err_q + 4'd1;
          end
          fail_d[idx_q] = 1'b1;
        end
        if (idx_q == IdxW'(NUM_VECTORS - 1)) begin
          state_d = StDone;
        end else begin
          state_d = StApply;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides every transition, including an accepted start.
    if (abort) begin
      state_d = StIdle;
      idx_d   = '0;
      err_d   = '0;
      fail_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a         = idx_q[2];
  assign b         = idx_q[1];
  assign c         = idx_q[0];
  assign busy      = settling || (state_q == StCheck);
  assign done      = (state_q == StDone);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_minority_bist.sv
// Randomized self-checking bench for minority_bist. Two instances share stimulus: one with
// SETTLE=1 and one with SETTLE=0. The gate under test is modelled in the bench (correct,
// stuck-at-0, majority, or a random per-vector fault mask); expected results come from
// re-evaluating each vector against the popcount rule.
module tb_minority_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort;

  logic       y1, a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [7:0] fv1;
  logic       y0, a0, b0, c0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [7:0] fv0;

  minority_bist #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .y_dut(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1)
  );

  minority_bist #(.SETTLE(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .y_dut(y0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fv0)
  );

  int         mode1 = 0, mode0 = 0;
  logic [7:0] mask1 = '0, mask0 = '0;
  bit         sel0  = 1'b0;

  // Gate model: 0 correct, 1 stuck-at-0, 2 majority, 3 correct with per-vector inversion mask.
  function automatic logic gate(input int mode, input logic [2:0] v, input logic [7:0] mask);
    int ones;
    ones = $countones(v);
    case (mode)
      0:       return ones < 2;
      1:       return 1'b0;
      2:       return ones >= 2;
      default: return (ones < 2) ^ mask[v];
    endcase
  endfunction

  function automatic logic [7:0] exp_fail(input int mode, input logic [7:0] mask);
    logic [7:0] r;
    logic [2:0] vv;
    r = '0;
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      if (gate(mode, vv, mask) != ($countones(vv) < 2)) r[v] = 1'b1;
    end
    return r;
  endfunction

  always_comb y1 = gate(mode1, {a1, b1, c1}, mask1);
  always_comb y0 = gate(mode0, {a0, b0, c0}, mask0);

  logic [2:0] o_abc;
  logic       o_busy, o_done, o_pass;
  logic [3:0] o_err;
  logic [7:0] o_fv;

  always_comb begin
    if (sel0) begin
      o_abc = {a0, b0, c0}; o_busy = busy0; o_done = done0; o_pass = pass0;
      o_err = err0; o_fv = fv0;
    end else begin
      o_abc = {a1, b1, c1}; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_err = err1; o_fv = fv1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_pass"}, 32'(o_pass), 32'd0);
    check({tag, "_abc"},  32'(o_abc),  32'd0);
    check({tag, "_err"},  32'(o_err),  32'd0);
    check({tag, "_fv"},   32'(o_fv),   32'd0);
  endtask

  // inj: 0 none, 1 abort, 2 reset together with start; applied at sample index inj_at.
  task automatic run_sweep(input int mode, input logic [7:0] mask, input int inj,
                           input int inj_at, input bit noise);
    int         s;
    int         lat;
    int         j;
    logic [7:0] ef;
    s   = sel0 ? 0 : 1;
    lat = 8 * (s + 2);
    ef  = exp_fail(mode, mask);
    j   = 0;
    if (sel0) begin mode0 = mode; mask0 = mask; end
    else      begin mode1 = mode; mask1 = mask; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_drops", 32'(o_done), 32'd0);
    while (!o_done && j <= lat + 4) begin
      check("busy", 32'(o_busy), 32'd1);
      check("vec", 32'(o_abc), 32'(j / (s + 2)));
      if (inj != 0 && j == inj_at) begin
        if (inj == 1) abort = 1'b1;
        else begin reset = 1'b1; start = 1'b1; end
        @(posedge clk); #1;
        abort = 1'b0; reset = 1'b0; start = 1'b0;
        check_idle(inj == 1 ? "abort" : "reset");
        return;
      end
      if (noise) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      j++;
    end
    start = 1'b0;
    check("latency",   32'(j),      32'(lat));
    check("done",      32'(o_done), 32'd1);
    check("busy_done", 32'(o_busy), 32'd0);
    check("err",       32'(o_err),  32'($countones(ef)));
    check("fail_vec",  32'(o_fv),   32'(ef));
    check("pass",      32'(o_pass), 32'(ef == 8'd0));
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", 32'(o_done), 32'd1);
    check("hold_err",  32'(o_err),  32'($countones(ef)));
    check("hold_fv",   32'(o_fv),   32'(ef));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sel0 = 1'b0; check_idle("rst1");
    sel0 = 1'b1; check_idle("rst0");
    sel0 = 1'b0;
    // Start held high during reset must not leave anything running.
    start = 1'b1;
    @(posedge clk); #1;
    check_idle("rst_start");
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    run_sweep(0, 8'h00, 0, 0, 1'b0);
    check("good_pass", 32'(o_pass), 32'd1);

    run_sweep(1, 8'h00, 0, 0, 1'b0);
    check("stuck0_err", 32'(o_err), 32'd4);
    check("stuck0_fv",  32'(o_fv),  32'h17);

    run_sweep(2, 8'h00, 0, 0, 1'b0);
    check("maj_err", 32'(o_err), 32'd8);
    check("maj_fv",  32'(o_fv),  32'hff);

    for (int k = 0; k < 4; k++) run_sweep(3, 8'($urandom), 0, 0, 1'b1);

    // Abort in CHECK of vector 5 (sample index 5*3+2), with a recorded error to clear.
    run_sweep(3, 8'h08, 1, 17, 1'b0);
    run_sweep(0, 8'h00, 0, 0, 1'b0);

    // Reset together with start in WAIT of vector 3 (sample index 3*3+1).
    run_sweep(3, 8'h08, 2, 10, 1'b0);
    @(posedge clk); #1;
    check_idle("post_reset");

    sel0 = 1'b1;
    run_sweep(0, 8'h00, 0, 0, 1'b0);
    check("s0_pass", 32'(o_pass), 32'd1);
    run_sweep(3, 8'($urandom), 0, 0, 1'b1);
    run_sweep(2, 8'h00, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
